sgmii_reg_bridge: RTL and testbench

SGMII_REG_BRIDGE -- requirements
Module: sgmii_reg_bridge

---
 rtl/sgmii_reg_pkg.sv | 26 ++
 rtl/sgmii_reg_timer.sv | 30 +++
 rtl/sgmii_reg_bridge.sv | 151 +++++++++++++++
 tb/tb_sgmii_reg_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sgmii_reg_pkg.sv
// Shared types and PCS register map for the SGMII configuration bridge.
package sgmii_reg_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Captured upstream request, held on the Avalon side for the whole access.
  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [ADDR_W-1:0] PCS_CONTROL     = 5'h00;
  localparam logic [ADDR_W-1:0] PCS_STATUS      = 5'h01;
  localparam logic [ADDR_W-1:0] PCS_LINK_TIMER0 = 5'h12;
  localparam logic [ADDR_W-1:0] PCS_LINK_TIMER1 = 5'h13;
  localparam logic [ADDR_W-1:0] PCS_IF_MODE     = 5'h14;

endpackage

// File: rtl/sgmii_reg_timer.sv
// Saturating wait-cycle counter; flags expiry when TIMEOUT_CYC-1 stalled cycles are seen.
module sgmii_reg_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_count;

  // Holds at the terminal count so it can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired_c) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired_c = (r_count == CNT_LAST);

endmodule

// File: rtl/sgmii_reg_bridge.sv
// Bridges level-style PCS config requests onto an Avalon-MM register port,
// with a waitrequest timeout and read-result holding.
module sgmii_reg_bridge
  import sgmii_reg_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYC = 1024,
  parameter logic [DATA_W-1:0] RD_ERR_DATA = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              cfg_wr,
  input  logic              cfg_rd,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              cfg_busy,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_write,
  output logic              av_read,
  output logic [DATA_W-1:0] av_writedata,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_waitrequest,
  output logic              timeout_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  req_t              r_req;
  req_t              w_req_nxt;
  logic              r_av_write;
  logic              w_av_write_nxt;
  logic              r_av_read;
  logic              w_av_read_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              r_timeout_err;
  logic              w_timeout_err_nxt;

  logic w_capture;
  logic w_complete;
  logic w_abort;
  logic w_expired;

  assign w_capture  = (r_state == ST_IDLE) && (cfg_wr || cfg_rd);
  assign w_complete = (r_state == ST_ACCESS) && !av_waitrequest;
  // Completion takes priority: a zero waitrequest on the last allowed cycle still finishes.
  assign w_abort    = (r_state == ST_ACCESS) && av_waitrequest && w_expired;

  sgmii_reg_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_capture),
    .i_enable    ((r_state == ST_ACCESS) && av_waitrequest),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_capture) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_complete || w_abort) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; cfg_* is only looked at while idle.
  always_comb begin
    w_req_nxt         = r_req;
    w_av_write_nxt    = r_av_write;
    w_av_read_nxt     = r_av_read;
    w_busy_nxt        = r_busy;
    w_rdata_nxt       = r_rdata;
    w_timeout_err_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_req_nxt.is_wr = cfg_wr;
          w_req_nxt.addr  = cfg_addr;
          w_req_nxt.wdata = cfg_wdata;
          w_av_write_nxt  = cfg_wr;
          w_av_read_nxt   = !cfg_wr;
          w_busy_nxt      = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (w_complete) begin
          w_av_write_nxt = 1'b0;
          w_av_read_nxt  = 1'b0;
          w_busy_nxt     = 1'b0;
          if (!r_req.is_wr) w_rdata_nxt = av_readdata;
        end else if (w_abort) begin
          w_av_write_nxt    = 1'b0;
          w_av_read_nxt     = 1'b0;
          w_busy_nxt        = 1'b0;
          w_timeout_err_nxt = 1'b1;
          if (!r_req.is_wr) w_rdata_nxt = RD_ERR_DATA;
        end
      end
      ST_DONE: begin
        w_av_write_nxt = 1'b0;
        w_av_read_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;
      end
      default: begin
        w_av_write_nxt = 1'b0;
        w_av_read_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req         <= '0;
      r_av_write    <= 1'b0;
      r_av_read     <= 1'b0;
      r_busy        <= 1'b0;
      r_rdata       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req         <= w_req_nxt;
      r_av_write    <= w_av_write_nxt;
      r_av_read     <= w_av_read_nxt;
      r_busy        <= w_busy_nxt;
      r_rdata       <= w_rdata_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign av_address   = r_req.addr;
  assign av_writedata = r_req.wdata;
  assign av_write     = r_av_write;
  assign av_read      = r_av_read;
  assign cfg_busy     = r_busy;
  assign cfg_rdata    = r_rdata;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_sgmii_reg_bridge.sv
// Scoreboard bench for sgmii_reg_bridge: an Avalon responder with programmable
// wait states, and a bus monitor comparing each finished strobe against the queue.
module tb_sgmii_reg_bridge;

  localparam int unsigned TMO = 16;

  logic        clk;
  logic        reset;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_wr;
  logic        cfg_rd;
  logic [15:0] cfg_rdata;
  logic        cfg_busy;
  logic [4:0]  av_address;
  logic        av_write;
  logic        av_read;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_waitrequest;
  logic        timeout_err;

  sgmii_reg_bridge #(
    .TIMEOUT_CYC (TMO),
    .RD_ERR_DATA (16'hFFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_wr         (cfg_wr),
    .cfg_rd         (cfg_rd),
    .cfg_rdata      (cfg_rdata),
    .cfg_busy       (cfg_busy),
    .av_address     (av_address),
    .av_write       (av_write),
    .av_read        (av_read),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [4:0]  addr;
    logic [15:0] data;
    int          len;
    logic        aborted;
    logic [15:0] rdata;
    int          gap;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_terr   = 0;
  int n_abort_exp = 0;
  int excl_err = 0;
  int wait_cfg = 0;
  logic [15:0] rd_value = 16'h0000;
  bit skip_next = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor + responder, both evaluated away from the active edge.
  bit          prev_strobe = 1'b0;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [15:0] m_data;
  bit          m_stable;
  bit          m_busy;
  bit          m_last_wait;
  int          m_len = 0;
  int          m_gap = 0;
  int          lo_cnt = 100;

  always @(negedge clk) begin
    exp_t e;
    bit strobe;
    strobe = av_write | av_read;
    if (av_write && av_read) excl_err++;
    if (timeout_err) n_terr++;
    if (strobe) begin
      if (!prev_strobe) begin
        m_wr = av_write; m_addr = av_address; m_data = av_writedata;
        m_stable = 1'b1; m_len = 0; m_gap = lo_cnt; m_busy = cfg_busy;
      end else if (av_write != m_wr || av_address != m_addr || (m_wr && av_writedata != m_data)) begin
        m_stable = 1'b0;
      end
      m_len++;
      av_waitrequest = (m_len <= wait_cfg);
      m_last_wait = av_waitrequest;
      lo_cnt = 0;
    end else begin
      if (prev_strobe) begin
        if (skip_next) begin
          skip_next = 1'b0;
        end else if (sb_q.size() == 0) begin
          check("unexpected_access", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("type", 32'(m_wr), 32'(e.is_wr));
          check("addr", 32'(m_addr), 32'(e.addr));
          if (e.is_wr) check("wdata", 32'(m_data), 32'(e.data));
          check("strobe_len", 32'(m_len), 32'(e.len));
          check("stable", 32'(m_stable), 1);
          check("busy_rise", 32'(m_busy), 1);
          check("aborted", 32'(m_last_wait), 32'(e.aborted));
          check("timeout_err", 32'(timeout_err), 32'(e.aborted));
          check("busy_fall", 32'(cfg_busy), 0);
          if (!e.is_wr) check("rdata", 32'(cfg_rdata), 32'(e.rdata));
          if (e.gap != 0) check("gap", 32'(m_gap), 32'(e.gap));
          n_done++;
        end
      end
      lo_cnt++;
      av_waitrequest = 1'b0;
    end
    prev_strobe = strobe;
    av_readdata = rd_value;
  end

  task automatic push_exp(input logic wr, input logic [4:0] addr, input logic [15:0] data,
                          input int waits, input logic [15:0] rdval, input int gap);
    exp_t e;
    e.is_wr   = wr;
    e.addr    = addr;
    e.data    = data;
    e.aborted = (waits >= int'(TMO));
    e.len     = e.aborted ? int'(TMO) : waits + 1;
    e.rdata   = e.aborted ? 16'hFFFF : rdval;
    e.gap     = gap;
    if (e.aborted) n_abort_exp++;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input bit scramble, input logic [4:0] addr,
                           input logic [15:0] data);
    for (int c = 0; c < 300 && n_done < target; c++) begin
      @(posedge clk); #2;
      if (scramble && cfg_busy) begin
        cfg_addr  = ~addr;
        cfg_wdata = ~data;
      end
    end
    check("done_bound", 32'(n_done >= target), 1);
  endtask

  // Issue one level request (wr/rd may both be set) held until n_rep accesses finish.
  task automatic run_access(input logic wr, input logic rd, input logic [4:0] addr,
                            input logic [15:0] data, input int waits,
                            input logic [15:0] rdval, input int n_rep);
    int target;
    target = n_done + n_rep;
    for (int r = 0; r < n_rep; r++) push_exp(wr, addr, data, waits, rdval, (r > 0) ? 2 : 0);
    wait_cfg = waits;
    rd_value = rdval;
    @(posedge clk); #2;
    cfg_addr = addr; cfg_wdata = data; cfg_wr = wr; cfg_rd = rd;
    wait_done(target, n_rep == 1, addr, data);
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int target;
    reset = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; cfg_wr = 1'b0; cfg_rd = 1'b0;
    av_waitrequest = 1'b0; av_readdata = '0;
    #1;
    check("rst_write", 32'(av_write), 0);
    check("rst_read", 32'(av_read), 0);
    check("rst_busy", 32'(cfg_busy), 0);
    check("rst_terr", 32'(timeout_err), 0);
    check("rst_rdata", 32'(cfg_rdata), 0);
    check("rst_addr", 32'(av_address), 0);
    check("rst_wdata", 32'(av_writedata), 0);
    #21 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Write with three wait states.
    run_access(1'b1, 1'b0, 5'h12, 16'h0D40, 3, 16'h0000, 1);
    // Zero-wait read, polled twice.
    run_access(1'b0, 1'b1, 5'h00, 16'h0000, 0, 16'h1140, 2);
    // Simultaneous write and read requests: write only.
    run_access(1'b1, 1'b1, 5'h00, 16'h9140, 1, 16'h5555, 1);
    // Timeout boundary: last allowed cycle completes, one more aborts.
    run_access(1'b0, 1'b1, 5'h01, 16'h0000, int'(TMO) - 1, 16'h2222, 1);
    run_access(1'b0, 1'b1, 5'h01, 16'h0000, 1000, 16'h3333, 1);
    run_access(1'b1, 1'b0, 5'h13, 16'h0007, 1000, 16'h0000, 1);

    // Reset on the second ACCESS cycle, then a fresh capture that must see a full timeout.
    wait_cfg = 1000;
    @(posedge clk); #2;
    cfg_addr = 5'h14; cfg_wdata = 16'h000B; cfg_wr = 1'b1;
    @(posedge clk); #2;
    check("pre_rst_busy", 32'(cfg_busy), 1);
    @(posedge clk); #2;
    skip_next = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_write", 32'(av_write), 0);
    check("mid_rst_busy", 32'(cfg_busy), 0);
    check("mid_rst_rdata", 32'(cfg_rdata), 0);
    check("mid_rst_addr", 32'(av_address), 0);
    check("mid_rst_terr", 32'(timeout_err), 0);
    target = n_done + 1;
    push_exp(1'b1, 5'h14, 16'h000B, 1000, 16'h0000, 0);
    #4 reset = 1'b1;
    wait_done(target, 1'b0, 5'h14, 16'h000B);
    cfg_wr = 1'b0;
    repeat (3) @(posedge clk);

    // Upstream configuration sequence.
    run_access(1'b1, 1'b0, 5'h12, 16'h0D40, 0, 16'h0000, 1);
    run_access(1'b1, 1'b0, 5'h13, 16'h0003, 1, 16'h0000, 1);
    run_access(1'b1, 1'b0, 5'h14, 16'h000B, 2, 16'h0000, 1);
    run_access(1'b1, 1'b0, 5'h00, 16'h1140, 0, 16'h0000, 1);
    run_access(1'b1, 1'b0, 5'h00, 16'h9140, 5, 16'h0000, 1);
    run_access(1'b0, 1'b1, 5'h00, 16'h0000, 0, 16'h0140, 3);

    repeat (4) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 0);
    check("exclusive", 32'(excl_err), 0);
    check("terr_pulses", 32'(n_terr), 32'(n_abort_exp));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
